csr_access_arb: RTL and testbench
=================================

Name: csr_access_arb

Overview:
- Serialises CSR instructions (csrrd / csrwr / csrxchg) from the two issue slots onto the CSR file's single read/write port pair.
- Performs the read-modify-write for csrxchg and returns the old CSR value to the requesting slot.
- Holds writes off while an exception is being committed, so a CSR write never collides with the exception update.
- Sits between the EXE stage and the csr block, and emits a fence pulse after writes that change address translation.

Parameters:
- CRMD_ADDR, 14'h000, CRMD address (fence trigger)
- DMW0_ADDR, 14'h180, DMW0 address (fence trigger)
- DMW1_ADDR, 14'h181, DMW1 address (fence trigger)
- CNT_W, 16, width of the stall and completion counters

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- req0_valid / req1_valid, in, 1, slot request valid; slot 0 is older in program order
- req0_ready / req1_ready, out, 1, request accepted this cycle
- req0_op / req1_op, in, 2, 00 rd, 01 wr, 10 xchg, 11 reserved (treated as rd)
- req0_addr / req1_addr, in, 14, CSR number
- req0_wdata / req1_wdata, in, 32, write data
- req0_mask / req1_mask, in, 32, xchg mask
- req0_tag / req1_tag, in, 5, destination register tag
- resp_valid, out, 1, response valid
- resp_ready, in, 1, response consumed
- resp_src, out, 1, slot that issued the request
- resp_tag, out, 5, tag of the request
- resp_rdata, out, 32, old CSR value
- csr_raddr, out, 14, to the CSR file read port
- csr_rdata, in, 32, combinational read data
- csr_waddr, out, 14, CSR write address
- csr_wen, out, 1, CSR write enable
- csr_wdata, out, 32, CSR write data
- in_excp, in, 1, exception or ertn committing this cycle
- flush, in, 1, pipeline flush
- xlat_fence, out, 1, one-cycle pulse after a CRMD/DMW write
- stall_cnt, out, CNT_W, cycles spent held off by in_excp (saturating)
- done_cnt, out, CNT_W, completed writes (wrapping)

Behaviour:
- Reset values: state IDLE. All outputs 0, including resp_*, csr_wen, csr_raddr, csr_waddr, csr_wdata, xlat_fence and both counters.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req0_ready = ~flush.
  - req1_ready = ~flush & ~req0_valid (fixed priority to the older slot).
  - On accept, latch op/addr/wdata/mask/tag/src and go to READ.
- READ (1 cycle):
  - csr_raddr = latched addr.
  - Register csr_rdata into old.
  - Next state: WRITE if op is wr or xchg, else RESP.
- WRITE:
  - If in_excp=1: csr_wen=0, stay in WRITE, stall_cnt++ (saturates at all-ones).
  - Else: csr_wen=1 for exactly one cycle, csr_waddr = addr.
    - wr: csr_wdata = wdata.
    - xchg: csr_wdata = (old & ~mask) | (wdata & mask).
    - Then done_cnt++ (wraps) and go to RESP.
  - If addr is CRMD_ADDR, DMW0_ADDR or DMW1_ADDR, xlat_fence=1 in the cycle after the csr_wen cycle.
- RESP:
  - resp_valid=1 with rdata=old, tag, src.
  - Hold all response fields stable until resp_ready; return to IDLE on the cycle resp_ready=1.
  - No new request is accepted in that same cycle.
- csr_wen is never 0→1 in a cycle with in_excp=1. This holds even if in_excp rises in the same cycle the FSM would write.
- flush:
  - In IDLE: blocks acceptance.
  - In READ or WRITE: abort to IDLE next cycle with no write, no response and no counter change.
  - In RESP: drop the response (resp_valid=0 next cycle) and go to IDLE.
  - A write already performed is not undone; its xlat_fence pulse still fires.
- Latency:
  - rd: accept → resp_valid after 2 cycles.
  - wr/xchg: 3 cycles plus the number of in_excp stall cycles.
- Throughput: one request per 3–4 cycles; back-to-back requests from the same slot are served in order.
- Reset mid-operation: return to IDLE immediately. Any pending write is not issued and counters clear.

Test Plan:
- csrrd: req0 rd addr 0x30 (SAVE0=0x12345678) → csr_raddr=0x30 at T+1; resp_valid at T+2, rdata=0x12345678, src=0; csr_wen stays 0.
- csrxchg: req1 xchg addr 0x4, old=0xFFFF_0000, wdata=0x0000_1234, mask=0x0000_FF00 → csr_wen pulse with csr_wdata=0xFFFF_1200; rdata=0xFFFF_0000; done_cnt=1.
- Simultaneous requests: req0 wr 0x31 and req1 rd 0x31 in the same cycle → req0 accepted, req1_ready=0. req1 is served after req0's response; it returns the new value.
- Exception hold: in_excp high for 3 cycles while in WRITE → csr_wen=0 for those cycles, then a single pulse; stall_cnt=3.
- Fence: wr DMW0_ADDR with wdata 0xA0000011 → xlat_fence=1 exactly one cycle after csr_wen. A wr to 0x30 never pulses xlat_fence.
- Flush and backpressure:
  - flush in READ → no csr_wen, no resp, IDLE next cycle.
  - Hold resp_ready=0 for 5 cycles → resp fields stable throughout; accept resumes after the handshake.

Source files
------------

// File: rtl/csr_access_arb_if.sv
// Request, response, CSR-port and control signals shared by the CSR access arbiter
// and its EXE-stage / csr-file neighbours.
interface csr_access_arb_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [13:0]      req0_addr;
    logic [31:0]      req0_wdata;
    logic [31:0]      req0_mask;
    logic [4:0]       req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [13:0]      req1_addr;
    logic [31:0]      req1_wdata;
    logic [31:0]      req1_mask;
    logic [4:0]       req1_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_src;
    logic [4:0]       resp_tag;
    logic [31:0]      resp_rdata;

    logic [13:0]      csr_raddr;
    logic [31:0]      csr_rdata;
    logic [13:0]      csr_waddr;
    logic             csr_wen;
    logic [31:0]      csr_wdata;

    logic             in_excp;
    logic             flush;
    logic             xlat_fence;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  req0_valid, req0_op, req0_addr, req0_wdata, req0_mask, req0_tag,
        input  req1_valid, req1_op, req1_addr, req1_wdata, req1_mask, req1_tag,
        output req0_ready, req1_ready,
        output resp_valid, resp_src, resp_tag, resp_rdata,
        input  resp_ready,
        output csr_raddr, csr_waddr, csr_wen, csr_wdata,
        input  csr_rdata,
        input  in_excp, flush,
        output xlat_fence, stall_cnt, done_cnt
    );

    modport master (
        output req0_valid, req0_op, req0_addr, req0_wdata, req0_mask, req0_tag,
        output req1_valid, req1_op, req1_addr, req1_wdata, req1_mask, req1_tag,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_src, resp_tag, resp_rdata,
        output resp_ready,
        input  csr_raddr, csr_waddr, csr_wen, csr_wdata,
        output csr_rdata,
        output in_excp, flush,
        input  xlat_fence, stall_cnt, done_cnt
    );
endinterface

// File: rtl/csr_access_arb.sv
// Serialises CSR rd/wr/xchg from two issue slots onto the single CSR port pair,
// holding writes off during exception commit and fencing after translation writes.
module csr_access_arb #(
    parameter logic [13:0] CRMD_ADDR = 14'h000,
    parameter logic [13:0] DMW0_ADDR = 14'h180,
    parameter logic [13:0] DMW1_ADDR = 14'h181,
    parameter int unsigned CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    csr_access_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [13:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mask_q, mask_d;
    logic [31:0]      old_q, old_d;
    logic [4:0]       tag_q, tag_d;
    logic             src_q, src_d;
    logic             fence_q, fence_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] done_q, done_d;

    logic             req0_rdy, req1_rdy;
    logic             resp_vld;
    logic [13:0]      raddr, waddr;
    logic             wen;
    logic [31:0]      wdata;

    logic             is_wr, is_xchg, is_xlat;
    logic             take0, take1;
    logic [31:0]      merged;

    assign is_wr   = (op_q == 2'b01) || (op_q == 2'b10);
    assign is_xchg = (op_q == 2'b10);
    assign is_xlat = (addr_q == CRMD_ADDR) || (addr_q == DMW0_ADDR) ||
                     (addr_q == DMW1_ADDR);
    assign merged  = (old_q & ~mask_q) | (wdata_q & mask_q);

    // Slot 0 is older, so it always wins a simultaneous request.
    assign take0 = bus.req0_valid & ~bus.flush;
    assign take1 = bus.req1_valid & ~bus.req0_valid & ~bus.flush;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        old_d    = old_q;
        tag_d    = tag_q;
        src_d    = src_q;
        fence_d  = 1'b0;
        stall_d  = stall_q;
        done_d   = done_q;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;
        resp_vld = 1'b0;
        raddr    = '0;
        waddr    = '0;
        wen      = 1'b0;
        wdata    = '0;

        unique case (state_q)
            IDLE: begin
                req0_rdy = ~bus.flush;
                req1_rdy = ~bus.flush & ~bus.req0_valid;
                if (take0 || take1) begin
                    op_d    = take1 ? bus.req1_op    : bus.req0_op;
                    addr_d  = take1 ? bus.req1_addr  : bus.req0_addr;
                    wdata_d = take1 ? bus.req1_wdata : bus.req0_wdata;
                    mask_d  = take1 ? bus.req1_mask  : bus.req0_mask;
                    tag_d   = take1 ? bus.req1_tag   : bus.req0_tag;
                    src_d   = take1;
                    state_d = READ;
                end
            end
            READ: begin
                raddr = addr_q;
                old_d = bus.csr_rdata;
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = is_wr ? WRITE : RESP;
                end
            end
            WRITE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.in_excp) begin
                    if (stall_q != {CNT_W{1'b1}}) begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    // Gated by rst so a reset in this cycle never lets the write out.
                    wen     = ~rst;
                    waddr   = addr_q;
                    wdata   = is_xchg ? merged : wdata_q;
                    done_d  = done_q + 1'b1;
                    fence_d = is_xlat;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_vld = 1'b1;
                if (bus.resp_ready || bus.flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            old_q   <= '0;
            tag_q   <= '0;
            src_q   <= 1'b0;
            fence_q <= 1'b0;
            stall_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            old_q   <= old_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            fence_q <= fence_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    assign bus.req0_ready = req0_rdy;
    assign bus.req1_ready = req1_rdy;
    assign bus.resp_valid = resp_vld;
    assign bus.resp_src   = resp_vld & src_q;
    assign bus.resp_tag   = resp_vld ? tag_q : 5'd0;
    assign bus.resp_rdata = resp_vld ? old_q : 32'd0;
    assign bus.csr_raddr  = raddr;
    assign bus.csr_waddr  = waddr;
    assign bus.csr_wen    = wen;
    assign bus.csr_wdata  = wdata;
    assign bus.xlat_fence = fence_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.done_cnt   = done_q;
endmodule

// File: tb/tb_csr_access_arb.sv
// Self-checking bench for csr_access_arb: vector table, corner sequences,
// and random traffic against a transaction-level CSR model.
module tb_csr_access_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_access_arb_if #(.CNT_W(16)) bus ();

    csr_access_arb #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // CSR file environment: combinational read, clocked write
    bit [31:0]   csrmem [16384];
    logic        pre_en = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    assign bus.csr_rdata = csrmem[bus.csr_raddr];
    always @(posedge clk) begin
        if (pre_en) csrmem[pre_addr] <= pre_data;
        else if (bus.csr_wen) csrmem[bus.csr_waddr] <= bus.csr_wdata;
    end

    // Reference model state
    bit [31:0] ref_mem [16384];
    int exp_done = 0;
    int exp_stall = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int        slot;
        bit [1:0]  op;
        bit [13:0] addr;
        bit [31:0] wd;
        bit [31:0] mk;
        int        excp;
        int        hold;
        bit [31:0] exp_rd;
        bit [31:0] exp_wd;
        bit        exp_fence;
    } vec_t;
    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic model_txn(input bit [1:0] op, input bit [13:0] a, input bit [31:0] wd,
                             input bit [31:0] mk, output bit [31:0] rd,
                             output bit [31:0] nw, output bit fence);
        bit wr;
        wr = (op == 2'd1) || (op == 2'd2);
        rd = ref_mem[a];
        if (op == 2'd1) nw = wd;
        else if (op == 2'd2) nw = (rd & ~mk) | (wd & mk);
        else nw = rd;
        if (wr) ref_mem[a] = nw;
        fence = wr && (a == 14'h000 || a == 14'h180 || a == 14'h181);
    endtask

    task automatic drive(input int slot, input bit [1:0] op, input bit [13:0] a,
                         input bit [31:0] wd, input bit [31:0] mk, input bit [4:0] tag);
        if (slot == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_addr = a;
            bus.req0_wdata = wd; bus.req0_mask = mk; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_addr = a;
            bus.req1_wdata = wd; bus.req1_mask = mk; bus.req1_tag = tag;
        end
    endtask

    task automatic do_req(input int slot, input bit [1:0] op, input bit [13:0] a,
                          input bit [31:0] wd, input bit [31:0] mk, input bit [4:0] tag,
                          input int excp, input int hold, input bit [31:0] exp_rd,
                          input bit [31:0] exp_wd, input bit exp_fence);
        bit wr;
        wr = (op == 2'd1) || (op == 2'd2);
        drive(slot, op, a, wd, mk, tag);
        #1;
        chk("ready", slot ? bus.req1_ready : bus.req0_ready, 1);
        step();
        if (slot == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
        chk("raddr", bus.csr_raddr, a);
        chk("wen_read", bus.csr_wen, 0);
        step();
        if (wr) begin
            for (int i = 0; i < excp; i++) begin
                bus.in_excp = 1'b1;
                #1;
                chk("wen_excp", bus.csr_wen, 0);
                step();
                exp_stall++;
            end
            bus.in_excp = 1'b0;
            #1;
            chk("wen", bus.csr_wen, 1);
            chk("waddr", bus.csr_waddr, a);
            chk("wdata", bus.csr_wdata, exp_wd);
            exp_done++;
            step();
        end else begin
            chk("resp_early", bus.resp_valid, 1);
        end
        chk("fence", bus.xlat_fence, wr ? exp_fence : 1'b0);
        chk("resp_valid", bus.resp_valid, 1);
        chk("rdata", bus.resp_rdata, exp_rd);
        chk("tag", bus.resp_tag, tag);
        chk("src", bus.resp_src, slot);
        chk("wen_resp", bus.csr_wen, 0);
        chk("stall_cnt", bus.stall_cnt, exp_stall);
        chk("done_cnt", bus.done_cnt, exp_done);
        chk("busy_ready", bus.req0_ready, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_rdata", bus.resp_rdata, exp_rd);
            chk("hold_tag", bus.resp_tag, tag);
            chk("hold_src", bus.resp_src, slot);
        end
        bus.resp_ready = 1'b1;
        #1;
        step();
        bus.resp_ready = 1'b0;
        chk("resp_done", bus.resp_valid, 0);
        chk("fence_off", bus.xlat_fence, 0);
    endtask

    bit [31:0] m_rd, m_nw;
    bit        m_f;
    bit [13:0] addrs [7];

    initial begin
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_addr = 0;
        bus.req0_wdata = 0; bus.req0_mask = 0; bus.req0_tag = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_addr = 0;
        bus.req1_wdata = 0; bus.req1_mask = 0; bus.req1_tag = 0;
        bus.resp_ready = 0; bus.in_excp = 0; bus.flush = 0;

        tbl[0] = '{0, 2'd0, 14'h030, 32'h0, 32'h0, 0, 0, 32'h12345678, 32'h0, 1'b0};
        tbl[1] = '{1, 2'd2, 14'h004, 32'h00001234, 32'h0000FF00, 0, 0,
                   32'hFFFF0000, 32'hFFFF1200, 1'b0};
        tbl[2] = '{0, 2'd1, 14'h180, 32'hA0000011, 32'h0, 3, 0, 32'h0, 32'hA0000011, 1'b1};
        tbl[3] = '{0, 2'd1, 14'h030, 32'h11112222, 32'h0, 0, 5,
                   32'h12345678, 32'h11112222, 1'b0};
        tbl[4] = '{1, 2'd2, 14'h000, 32'hFFFFFFFF, 32'h0000000F, 0, 0,
                   32'h0, 32'h0000000F, 1'b1};
        tbl[5] = '{0, 2'd0, 14'h004, 32'h0, 32'h0, 0, 1, 32'hFFFF1200, 32'h0, 1'b0};
        tbl[6] = '{1, 2'd3, 14'h030, 32'h5555, 32'hFFFF, 0, 0, 32'h11112222, 32'h0, 1'b0};
        tbl[7] = '{0, 2'd1, 14'h181, 32'h00000005, 32'h0, 1, 2, 32'h0, 32'h5, 1'b1};

        step(); step();
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_wen", bus.csr_wen, 0);
        chk("rst_raddr", bus.csr_raddr, 0);
        chk("rst_waddr", bus.csr_waddr, 0);
        chk("rst_wdata", bus.csr_wdata, 0);
        chk("rst_fence", bus.xlat_fence, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_done", bus.done_cnt, 0);
        rst = 1'b0;
        preload(14'h030, 32'h12345678);
        preload(14'h004, 32'hFFFF0000);

        for (int i = 0; i < 8; i++) begin
            model_txn(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].mk, m_rd, m_nw, m_f);
            do_req(tbl[i].slot, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].mk,
                   5'(i + 3), tbl[i].excp, tbl[i].hold, tbl[i].exp_rd,
                   tbl[i].exp_wd, tbl[i].exp_fence);
        end

        // Simultaneous requests: slot 0 wins, slot 1 waits and sees the new value
        drive(1, 2'd0, 14'h031, 32'h0, 32'h0, 5'd21);
        drive(0, 2'd1, 14'h031, 32'hCAFEF00D, 32'h0, 5'd20);
        #1;
        chk("sim_r0", bus.req0_ready, 1);
        chk("sim_r1", bus.req1_ready, 0);
        model_txn(2'd1, 14'h031, 32'hCAFEF00D, 32'h0, m_rd, m_nw, m_f);
        do_req(0, 2'd1, 14'h031, 32'hCAFEF00D, 32'h0, 5'd20, 0, 0, m_rd, m_nw, m_f);
        model_txn(2'd0, 14'h031, 32'h0, 32'h0, m_rd, m_nw, m_f);
        do_req(1, 2'd0, 14'h031, 32'h0, 32'h0, 5'd21, 0, 0, m_rd, m_nw, m_f);
        chk("sim_newval", m_rd, 32'hCAFEF00D);

        // Flush in IDLE blocks acceptance
        bus.flush = 1'b1;
        drive(0, 2'd1, 14'h030, 32'hDEAD, 32'h0, 5'd1);
        #1;
        chk("flush_idle_r0", bus.req0_ready, 0);
        chk("flush_idle_r1", bus.req1_ready, 0);
        step();
        bus.flush = 1'b0;
        bus.req0_valid = 1'b0;
        #1;
        chk("flush_idle_noread", bus.csr_raddr, 0);

        // Flush in READ: no write, no response
        drive(0, 2'd1, 14'h030, 32'hDEAD, 32'h0, 5'd2);
        step();
        bus.req0_valid = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("flush_rd_wen", bus.csr_wen, 0);
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_rd_resp", bus.resp_valid, 0);
        chk("flush_rd_idle", bus.req0_ready, 1);
        chk("flush_rd_wen2", bus.csr_wen, 0);
        step();
        chk("flush_rd_wen3", bus.csr_wen, 0);
        chk("flush_rd_done", bus.done_cnt, exp_done);
        chk("flush_rd_mem", csrmem[14'h030], ref_mem[14'h030]);

        // Flush in WRITE while held off: no counter change
        drive(1, 2'd1, 14'h031, 32'hBEEF, 32'h0, 5'd3);
        step();
        bus.req1_valid = 1'b0;
        step();
        bus.flush = 1'b1;
        bus.in_excp = 1'b1;
        #1;
        chk("flush_wr_wen", bus.csr_wen, 0);
        step();
        bus.flush = 1'b0;
        bus.in_excp = 1'b0;
        #1;
        chk("flush_wr_stall", bus.stall_cnt, exp_stall);
        chk("flush_wr_done", bus.done_cnt, exp_done);
        chk("flush_wr_resp", bus.resp_valid, 0);
        chk("flush_wr_idle", bus.req1_ready, 1);

        // Flush in RESP drops the response
        drive(0, 2'd0, 14'h004, 32'h0, 32'h0, 5'd4);
        step();
        bus.req0_valid = 1'b0;
        step();
        chk("flush_resp_pre", bus.resp_valid, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_resp_drop", bus.resp_valid, 0);
        chk("flush_resp_idle", bus.req0_ready, 1);

        // Random traffic against the model
        addrs[0] = 14'h030; addrs[1] = 14'h031; addrs[2] = 14'h004; addrs[3] = 14'h000;
        addrs[4] = 14'h180; addrs[5] = 14'h181; addrs[6] = 14'h032;
        for (int n = 0; n < 40; n++) begin
            int        s, ex, hd;
            bit [1:0]  op;
            bit [13:0] a;
            bit [31:0] wd, mk;
            s  = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            a  = addrs[$urandom_range(0, 6)];
            wd = $urandom;
            mk = $urandom;
            ex = int'($urandom_range(0, 2));
            hd = int'($urandom_range(0, 2));
            model_txn(op, a, wd, mk, m_rd, m_nw, m_f);
            do_req(s, op, a, wd, mk, 5'(n), ex, hd, m_rd, m_nw, m_f);
        end
        for (int i = 0; i < 7; i++) begin
            chk("final_mem", csrmem[addrs[i]], ref_mem[addrs[i]]);
        end

        // Reset mid-write: pending write dropped, counters cleared
        drive(0, 2'd1, 14'h031, 32'h77777777, 32'h0, 5'd9);
        step();
        bus.req0_valid = 1'b0;
        step();
        bus.in_excp = 1'b1;
        step();
        chk("rst_mid_stall", bus.stall_cnt, exp_stall + 1);
        bus.in_excp = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_wen", bus.csr_wen, 0);
        step();
        rst = 1'b0;
        exp_stall = 0;
        exp_done = 0;
        #1;
        chk("rst_mid_stall0", bus.stall_cnt, 0);
        chk("rst_mid_done0", bus.done_cnt, 0);
        chk("rst_mid_idle", bus.req0_ready, 1);
        chk("rst_mid_resp", bus.resp_valid, 0);
        step();
        chk("rst_mid_mem", csrmem[14'h031], ref_mem[14'h031]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
